// File: rtl/car_parking_system.sv
// Single-lane car park gate controller.
// Password window, GO/EE/SP panel, blinking LEDs.
module car_parking_system #(
  parameter logic [31:0] WAIT_LIMIT = 32'd3,
  parameter logic [1:0]  PASS_1     = 2'b01,
  parameter logic [1:0]  PASS_2     = 2'b10
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       sensor_entrance,
  input  logic       sensor_exit,
  input  logic [1:0] password_1,
  input  logic [1:0] password_2,
  output logic       GREEN_LED,
  output logic       RED_LED,
  output logic [6:0] HEX_1,
  output logic [6:0] HEX_2
);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    WAIT_PASS  = 3'd1,
    WRONG_PASS = 3'd2,
    RIGHT_PASS = 3'd3,
    STOP       = 3'd4
  } state_t;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_E     = 7'b0000110;
  localparam logic [6:0] SEG_N     = 7'b0101011;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_P     = 7'b0001100;

  state_t      r_state;
  state_t      w_next;
  logic [31:0] r_cnt;
  logic        w_pass_ok;

  logic        r_green;
  logic        r_red;
  logic [6:0]  r_hex1;
  logic [6:0]  r_hex2;
  logic        w_green;
  logic        w_red;
  logic [6:0]  w_hex1;
  logic [6:0]  w_hex2;

  assign w_pass_ok = (password_1 == PASS_1) && (password_2 == PASS_2);

  // State register and wait counter (counts only while in WAIT_PASS)
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == WAIT_PASS) r_cnt <= r_cnt + 32'd1;
      else                      r_cnt <= '0;
    end
  end

  // Next-state decode
  always_comb begin
    w_next = IDLE;
    case (r_state)
      IDLE:
        w_next = sensor_entrance ? WAIT_PASS : IDLE;
      WAIT_PASS:
        if (r_cnt <= WAIT_LIMIT) w_next = WAIT_PASS;
        else if (w_pass_ok)      w_next = RIGHT_PASS;
        else                     w_next = WRONG_PASS;
      WRONG_PASS:
        w_next = w_pass_ok ? RIGHT_PASS : WRONG_PASS;
      RIGHT_PASS:
        if (sensor_entrance && sensor_exit) w_next = STOP;
        else if (sensor_exit)               w_next = IDLE;
        else                                w_next = RIGHT_PASS;
      STOP:
        w_next = w_pass_ok ? RIGHT_PASS : STOP;
      default:
        w_next = IDLE;
    endcase
  end

  // Panel values derived from the currently held state
  always_comb begin
    w_green = 1'b0;
    w_red   = 1'b0;
    w_hex1  = SEG_BLANK;
    w_hex2  = SEG_BLANK;
    case (r_state)
      WAIT_PASS: begin
        w_red  = 1'b1;
        w_hex1 = SEG_E;
        w_hex2 = SEG_N;
      end
      WRONG_PASS: begin
        w_red  = ~r_red;
        w_hex1 = SEG_E;
        w_hex2 = SEG_E;
      end
      RIGHT_PASS: begin
        w_green = ~r_green;
        w_hex1  = SEG_6;
        w_hex2  = SEG_0;
      end
      STOP: begin
        w_red  = ~r_red;
        w_hex1 = SEG_5;
        w_hex2 = SEG_P;
      end
      default: ;
    endcase
  end

  // Registered panel outputs, one cycle behind the state
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_green <= 1'b0;
      r_red   <= 1'b0;
      r_hex1  <= SEG_BLANK;
      r_hex2  <= SEG_BLANK;
    end else begin
      r_green <= w_green;
      r_red   <= w_red;
      r_hex1  <= w_hex1;
      r_hex2  <= w_hex2;
    end
  end

  assign GREEN_LED = r_green;
  assign RED_LED   = r_red;
  assign HEX_1     = r_hex1;
  assign HEX_2     = r_hex2;

endmodule

// File: tb/tb_car_parking_system.sv
// Bench for car_parking_system.
// Reference model feeds a scoreboard queue.
module tb_car_parking_system;

  logic       clk;
  logic       reset_n;
  logic       sensor_entrance;
  logic       sensor_exit;
  logic [1:0] password_1;
  logic [1:0] password_2;
  logic       GREEN_LED;
  logic       RED_LED;
  logic [6:0] HEX_1;
  logic [6:0] HEX_2;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       tag;
    logic [15:0] val;
  } exp_t;

  exp_t sb[$];

  localparam int S_IDLE  = 0;
  localparam int S_WAIT  = 1;
  localparam int S_WRONG = 2;
  localparam int S_RIGHT = 3;
  localparam int S_STOP  = 4;

  int         m_st;
  int         m_cnt;
  logic       m_g;
  logic       m_r;
  logic [6:0] m_h1;
  logic [6:0] m_h2;

  car_parking_system dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .sensor_entrance (sensor_entrance),
    .sensor_exit     (sensor_exit),
    .password_1      (password_1),
    .password_2      (password_2),
    .GREEN_LED       (GREEN_LED),
    .RED_LED         (RED_LED),
    .HEX_1           (HEX_1),
    .HEX_2           (HEX_2)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [15:0] obs,
                     input logic [15:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Advance the reference model by one rising edge
  task automatic model_edge();
    logic ok;
    int   nx;
    ok = (password_1 == 2'b01) && (password_2 == 2'b10);
    if (!reset_n) begin
      m_st  = S_IDLE;
      m_cnt = 0;
      m_g   = 1'b0;
      m_r   = 1'b0;
      m_h1  = 7'h7F;
      m_h2  = 7'h7F;
      return;
    end
    case (m_st)
      S_WAIT:  begin m_g = 0; m_r = 1;    m_h1 = 7'b0000110; m_h2 = 7'b0101011; end
      S_WRONG: begin m_g = 0; m_r = ~m_r; m_h1 = 7'b0000110; m_h2 = 7'b0000110; end
      S_RIGHT: begin m_g = ~m_g; m_r = 0; m_h1 = 7'b0000010; m_h2 = 7'b1000000; end
      S_STOP:  begin m_g = 0; m_r = ~m_r; m_h1 = 7'b0010010; m_h2 = 7'b0001100; end
      default: begin m_g = 0; m_r = 0;    m_h1 = 7'h7F;      m_h2 = 7'h7F;      end
    endcase
    nx = m_st;
    case (m_st)
      S_IDLE:  if (sensor_entrance) nx = S_WAIT;
      S_WAIT:  if (m_cnt > 3) nx = ok ? S_RIGHT : S_WRONG;
      S_WRONG: if (ok) nx = S_RIGHT;
      S_RIGHT: begin
        if (sensor_entrance && sensor_exit) nx = S_STOP;
        else if (sensor_exit)               nx = S_IDLE;
      end
      S_STOP:  if (ok) nx = S_RIGHT;
      default: nx = S_IDLE;
    endcase
    m_cnt = (m_st == S_WAIT) ? m_cnt + 1 : 0;
    m_st  = nx;
  endtask

  // Drive one cycle of stimulus, predict, then compare after the edge
  task automatic step(input string tag, input logic rn,
                      input logic en, input logic ex,
                      input logic [1:0] p1, input logic [1:0] p2);
    exp_t e;
    exp_t o;
    @(negedge clk);
    reset_n         = rn;
    sensor_entrance = en;
    sensor_exit     = ex;
    password_1      = p1;
    password_2      = p2;
    model_edge();
    e.tag = tag;
    e.val = {m_g, m_r, m_h1, m_h2};
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      chk({tag, "_empty"}, 16'h0, 16'hFFFF);
    end else begin
      o = sb.pop_front();
      chk(o.tag, {GREEN_LED, RED_LED, HEX_1, HEX_2}, o.val);
    end
  endtask

  initial begin
    reset_n = 0; sensor_entrance = 0; sensor_exit = 0;
    password_1 = 0; password_2 = 0;
    m_st = S_IDLE; m_cnt = 0;
    m_g = 0; m_r = 0; m_h1 = 7'h7F; m_h2 = 7'h7F;

    step("rst0", 0, 0, 0, 2'b00, 2'b00);
    step("rst1", 0, 0, 0, 2'b00, 2'b00);
    chk("rst_lit", {GREEN_LED, RED_LED, HEX_1, HEX_2}, {2'b00, 7'h7F, 7'h7F});

    for (int i = 0; i < 9; i++) step("go_en", 1, 1, 0, 2'b01, 2'b10);
    chk("go_lit", {RED_LED, HEX_1, HEX_2}, {1'b0, 7'b0000010, 7'b1000000});
    for (int i = 0; i < 3; i++) step("go_hold", 1, 0, 0, 2'b01, 2'b10);

    step("exit", 1, 0, 1, 2'b01, 2'b10);
    step("idle", 1, 0, 0, 2'b00, 2'b00);
    step("idle2", 1, 0, 0, 2'b00, 2'b00);
    chk("idle_lit", {GREEN_LED, RED_LED, HEX_1, HEX_2}, {2'b00, 7'h7F, 7'h7F});

    for (int i = 0; i < 9; i++) step("ee_en", 1, 1, 0, 2'b00, 2'b00);
    for (int i = 0; i < 2; i++) step("ee_hold", 1, 0, 0, 2'b11, 2'b10);
    for (int i = 0; i < 2; i++) step("ee_fix", 1, 0, 0, 2'b01, 2'b10);
    chk("ee_go_lit", {HEX_1, HEX_2}, {7'b0000010, 7'b1000000});

    step("stack", 1, 1, 1, 2'b01, 2'b10);
    for (int i = 0; i < 4; i++) step("sp_hold", 1, 0, 0, 2'b10, 2'b01);
    chk("sp_lit", {HEX_1, HEX_2}, {7'b0010010, 7'b0001100});
    for (int i = 0; i < 3; i++) step("sp_fix", 1, 0, 0, 2'b01, 2'b10);
    step("exit2", 1, 0, 1, 2'b00, 2'b00);
    step("idle3", 1, 0, 0, 2'b00, 2'b00);

    for (int i = 0; i < 8; i++) step("wr_en", 1, 1, 0, 2'b00, 2'b01);
    step("mid_rst", 0, 1, 0, 2'b00, 2'b01);
    chk("mid_rst_lit", {GREEN_LED, RED_LED, HEX_1, HEX_2}, {2'b00, 7'h7F, 7'h7F});
    step("post_rst", 1, 0, 0, 2'b00, 2'b00);
    for (int i = 0; i < 8; i++) step("re_en", 1, 1, 0, 2'b01, 2'b10);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
